// File: rtl/ayatsuki_bus_arbiter.sv
// Two-master single-beat bus arbiter with round-robin contention, bounded lock
// ownership, inclusive address decode to mem/timer/UART and registered read return.
module ayatsuki_bus_arbiter #(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter logic [ADDR_W-1:0] MEM_BASE  = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] MEM_END   = 32'h0000_07FF,
    parameter logic [ADDR_W-1:0] TIM_BASE  = 32'h0000_1000,
    parameter logic [ADDR_W-1:0] TIM_END   = 32'h0000_100F,
    parameter logic [ADDR_W-1:0] UART_BASE = 32'h0000_2000,
    parameter logic [ADDR_W-1:0] UART_END  = 32'h0000_200F,
    parameter int              MAX_LOCK  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic              m0_lock_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic              m1_lock_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m0_gnt_o,
    output logic              m1_gnt_o,
    output logic              m0_rvalid_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              s_mem_en_o,
    output logic              s_tim_en_o,
    output logic              s_uart_en_o,
    output logic              s_we_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_wdata_o,
    input  logic [DATA_W-1:0] s_mem_rdata_i,
    input  logic [DATA_W-1:0] s_tim_rdata_i,
    input  logic [DATA_W-1:0] s_uart_rdata_i,
    output logic              err_o
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam int               CNT_W     = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MAX_LOCK - 1);
    localparam logic [ADDR_W-1:0] MEM_SPAN  = MEM_END - MEM_BASE;
    localparam logic [ADDR_W-1:0] TIM_SPAN  = TIM_END - TIM_BASE;
    localparam logic [ADDR_W-1:0] UART_SPAN = UART_END - UART_BASE;

    state_t             r_state;
    logic               r_rr_last;
    logic [CNT_W-1:0]   r_lock_cnt;
    logic               r_m0_rvalid, r_m1_rvalid;
    logic [2:0]         r_sel;
    logic               r_err;
    logic [DATA_W-1:0]  r_m0_rdata, r_m1_rdata;

    logic               w_gnt0, w_gnt1, w_any, w_we, w_lock;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_wdata, w_rdata;
    logic               w_hit_mem, w_hit_tim, w_hit_uart, w_hit;

    // rr_last = 1 means master 0 wins the next contention.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (r_state)
            OWN0:    w_gnt0 = m0_req_i;
            OWN1:    w_gnt1 = m1_req_i;
            default: begin
                if (m0_req_i && m1_req_i) begin
                    w_gnt0 = r_rr_last;
                    w_gnt1 = !r_rr_last;
                end else begin
                    w_gnt0 = m0_req_i;
                    w_gnt1 = m1_req_i;
                end
            end
        endcase
    end

    assign w_any   = w_gnt0 | w_gnt1;
    assign w_addr  = w_gnt1 ? m1_addr_i  : m0_addr_i;
    assign w_wdata = w_gnt1 ? m1_wdata_i : m0_wdata_i;
    assign w_we    = w_gnt1 ? m1_we_i    : m0_we_i;
    assign w_lock  = w_gnt1 ? m1_lock_i  : m0_lock_i;

    // Offset compare gives an inclusive window with a single unsigned test.
    assign w_hit_mem  = (w_addr - MEM_BASE)  <= MEM_SPAN;
    assign w_hit_tim  = (w_addr - TIM_BASE)  <= TIM_SPAN;
    assign w_hit_uart = (w_addr - UART_BASE) <= UART_SPAN;
    assign w_hit      = w_hit_mem | w_hit_tim | w_hit_uart;

    assign m0_gnt_o    = w_gnt0;
    assign m1_gnt_o    = w_gnt1;
    assign s_mem_en_o  = w_any & w_hit_mem;
    assign s_tim_en_o  = w_any & w_hit_tim;
    assign s_uart_en_o = w_any & w_hit_uart;
    assign s_we_o      = w_any & w_we & w_hit;
    assign s_addr_o    = w_addr;
    assign s_wdata_o   = w_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rr_last  <= 1'b1;
            r_lock_cnt <= '0;
        end else begin
            case (r_state)
                OWN0, OWN1: begin
                    if (w_any) r_lock_cnt <= r_lock_cnt + 1'b1;
                    if (!w_any || !w_lock) begin
                        r_state <= IDLE;
                    end else if (r_lock_cnt == LOCK_LAST) begin
                        // Forced hand-over: the locked-out master wins next.
                        r_state   <= IDLE;
                        r_rr_last <= (r_state == OWN1);
                    end
                end
                default: begin
                    if (w_any) begin
                        if (m0_req_i && m1_req_i) r_rr_last <= w_gnt1;
                        if (w_lock && MAX_LOCK > 1) begin
                            r_state    <= w_gnt1 ? OWN1 : OWN0;
                            r_lock_cnt <= CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // r_sel is one-hot {uart, tim, mem}; all-zero marks a decode miss.
    always_comb begin
        w_rdata = '0;
        if (r_sel[0]) w_rdata = s_mem_rdata_i;
        if (r_sel[1]) w_rdata = s_tim_rdata_i;
        if (r_sel[2]) w_rdata = s_uart_rdata_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_sel       <= '0;
            r_err       <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
        end else begin
            r_m0_rvalid <= w_gnt0 & !m0_we_i;
            r_m1_rvalid <= w_gnt1 & !m1_we_i;
            r_err       <= w_any & !w_hit;
            if (w_any && !w_we) r_sel <= {w_hit_uart, w_hit_tim, w_hit_mem};
            if (r_m0_rvalid) r_m0_rdata <= w_rdata;
            if (r_m1_rvalid) r_m1_rdata <= w_rdata;
        end
    end

    // Slave data arrives in the rvalid cycle; the hold register keeps it afterwards.
    assign m0_rvalid_o = r_m0_rvalid;
    assign m1_rvalid_o = r_m1_rvalid;
    assign m0_rdata_o  = r_m0_rvalid ? w_rdata : r_m0_rdata;
    assign m1_rdata_o  = r_m1_rvalid ? w_rdata : r_m1_rdata;
    assign err_o       = r_err;

endmodule

// File: tb/tb_ayatsuki_bus_arbiter.sv
// Randomized + directed bench: per-cycle grant/decode checks against a
// behavioural model, read/err responses checked by a queue-driven monitor.
module tb_ayatsuki_bus_arbiter;
    localparam int MAX_LOCK = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        m0_req_i = 0, m0_we_i = 0, m0_lock_i = 0;
    logic        m1_req_i = 0, m1_we_i = 0, m1_lock_i = 0;
    logic [31:0] m0_addr_i = 0, m0_wdata_i = 0, m1_addr_i = 0, m1_wdata_i = 0;
    logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        s_mem_en_o, s_tim_en_o, s_uart_en_o, s_we_o, err_o;
    logic [31:0] s_addr_o, s_wdata_o;
    logic [31:0] mem_d = 0, tim_d = 0, uart_d = 0;

    ayatsuki_bus_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_lock_i(m0_lock_i),
        .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_lock_i(m1_lock_i),
        .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m0_gnt_o(m0_gnt_o), .m1_gnt_o(m1_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m1_rvalid_o(m1_rvalid_o),
        .m0_rdata_o(m0_rdata_o), .m1_rdata_o(m1_rdata_o),
        .s_mem_en_o(s_mem_en_o), .s_tim_en_o(s_tim_en_o), .s_uart_en_o(s_uart_en_o),
        .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
        .s_mem_rdata_i(mem_d), .s_tim_rdata_i(tim_d), .s_uart_rdata_i(uart_d),
        .err_o(err_o)
    );

    typedef struct {bit req; bit we; bit lock; logic [31:0] addr; logic [31:0] wdata;} mreq_t;
    typedef struct {int due; bit rd; bit owner; int sel;} exp_t;  // sel: 0 mem 1 tim 2 uart 3 miss

    exp_t        rq[$];
    int          total = 0, bad = 0, cyc = 0;
    int          own = -1, run = 0, pref = 0;  // model: lock owner, run length, contention winner
    logic [31:0] last_rd[2];
    bit          fix_sd = 0;
    logic [31:0] fix_mem = 0, fix_tim = 0, fix_uart = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int region(logic [31:0] a);
        if (a <= 32'h7FF) return 0;
        if (a >= 32'h1000 && a <= 32'h100F) return 1;
        if (a >= 32'h2000 && a <= 32'h200F) return 2;
        return 3;
    endfunction

    function automatic logic [31:0] sdata(int sel);
        case (sel)
            0: return mem_d;
            1: return tim_d;
            2: return uart_d;
            default: return 32'h0;
        endcase
    endfunction

    // Response monitor: pops the entry due this cycle and checks rvalid/rdata/err.
    exp_t        mon_e;
    bit          mon_v0, mon_v1, mon_err;
    logic [31:0] mon_d0, mon_d1;
    always @(negedge clk) begin
        mon_v0 = 0; mon_v1 = 0; mon_err = 0;
        mon_d0 = last_rd[0]; mon_d1 = last_rd[1];
        if (rq.size() > 0 && rq[0].due == cyc) begin
            mon_e = rq.pop_front();
            mon_err = (mon_e.sel == 3);
            if (mon_e.rd) begin
                if (mon_e.owner) begin mon_v1 = 1; mon_d1 = sdata(mon_e.sel); end
                else begin mon_v0 = 1; mon_d0 = sdata(mon_e.sel); end
            end
        end
        chk("m0_rvalid", m0_rvalid_o, mon_v0);
        chk("m1_rvalid", m1_rvalid_o, mon_v1);
        chk("m0_rdata", m0_rdata_o, mon_d0);
        chk("m1_rdata", m1_rdata_o, mon_d1);
        chk("err", err_o, mon_err);
        last_rd[0] = mon_d0;
        last_rd[1] = mon_d1;
    end

    // One bus cycle: drive, check combinational side against the model, queue responses.
    task automatic step(input mreq_t a, input mreq_t b, output int g, output bit dg0, output bit dg1);
        logic [31:0] ad, wd;
        bit we, lk;
        int r;
        @(posedge clk); #1;
        m0_req_i = a.req; m0_we_i = a.we; m0_lock_i = a.lock; m0_addr_i = a.addr; m0_wdata_i = a.wdata;
        m1_req_i = b.req; m1_we_i = b.we; m1_lock_i = b.lock; m1_addr_i = b.addr; m1_wdata_i = b.wdata;
        if (fix_sd) begin mem_d = fix_mem; tim_d = fix_tim; uart_d = fix_uart; end
        else begin mem_d = $urandom; tim_d = $urandom; uart_d = $urandom; end
        #3;
        if (own >= 0) g = ((own == 0) ? a.req : b.req) ? own : -1;
        else if (a.req && b.req) g = pref;
        else if (a.req) g = 0;
        else if (b.req) g = 1;
        else g = -1;
        dg0 = m0_gnt_o;
        dg1 = m1_gnt_o;
        chk("gnt0", m0_gnt_o, g == 0);
        chk("gnt1", m1_gnt_o, g == 1);
        if (g >= 0) begin
            ad = g ? b.addr : a.addr;
            wd = g ? b.wdata : a.wdata;
            we = g ? b.we : a.we;
            lk = g ? b.lock : a.lock;
            r = region(ad);
            chk("mem_en", s_mem_en_o, r == 0);
            chk("tim_en", s_tim_en_o, r == 1);
            chk("uart_en", s_uart_en_o, r == 2);
            chk("s_we", s_we_o, we && r != 3);
            chk("s_addr", s_addr_o, ad);
            if (we) chk("s_wdata", s_wdata_o, wd);
            if (!we || r == 3) rq.push_back('{cyc + 1, !we, g[0], r});
            if (own < 0) begin
                if (a.req && b.req) pref = 1 - g;
                if (lk) begin own = g; run = 1; end
            end else begin
                run++;
                if (!lk) own = -1;
                else if (run >= MAX_LOCK) begin pref = 1 - own; own = -1; end
            end
        end else begin
            chk("idle_en", {s_mem_en_o, s_tim_en_o, s_uart_en_o, s_we_o}, 4'b0);
            own = -1;
        end
    endtask

    function automatic mreq_t rnd();
        mreq_t m;
        m.req = ($urandom % 10) < 7;
        m.we = $urandom % 2;
        m.lock = ($urandom % 4) == 0;
        case ($urandom % 12)
            0: m.addr = 32'h0;      1: m.addr = 32'h7FF;   2: m.addr = 32'h800;
            3: m.addr = 32'h1000;   4: m.addr = 32'h100F;  5: m.addr = 32'h1010;
            6: m.addr = 32'h2000;   7: m.addr = 32'h200F;  8: m.addr = 32'h2010;
            9: m.addr = 32'h0FFF;   10: m.addr = $urandom % 32'h800;
            default: m.addr = $urandom;
        endcase
        m.wdata = $urandom;
        return m;
    endfunction

    function automatic mreq_t mk(bit we, bit lock, logic [31:0] addr, logic [31:0] wdata);
        mreq_t m;
        m.req = 1; m.we = we; m.lock = lock; m.addr = addr; m.wdata = wdata;
        return m;
    endfunction

    mreq_t z, pa, pb;
    int    g;
    bit    dg0, dg1;

    initial begin
        z = '{default: 0};
        last_rd[0] = 0;
        last_rd[1] = 0;
        #12;
        chk("rst_outs", {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, s_mem_en_o,
                         s_tim_en_o, s_uart_en_o, s_we_o, err_o}, 9'b0);
        chk("rst_rdata", m0_rdata_o | m1_rdata_o, 32'h0);
        @(negedge clk); rst = 0;

        step(mk(1, 0, 32'h10, 32'hA5), z, g, dg0, dg1);
        chk("wr_gnt", {dg0, s_mem_en_o, s_we_o}, 3'b111);

        fix_sd = 1; fix_tim = 32'h1234; fix_mem = 32'hDEAD; fix_uart = 32'hBEEF;
        step(mk(0, 0, 32'h1004, 0), z, g, dg0, dg1);
        step(z, z, g, dg0, dg1);
        chk("tim_rvalid", m0_rvalid_o, 1'b1);
        chk("tim_rdata", m0_rdata_o, 32'h1234);
        fix_sd = 0;

        step(mk(0, 0, 32'h3000, 0), z, g, dg0, dg1);
        step(z, z, g, dg0, dg1);
        chk("miss_rv", {m0_rvalid_o, err_o}, 2'b11);
        chk("miss_rdata", m0_rdata_o, 32'h0);
        step(z, z, g, dg0, dg1);
        chk("miss_err_once", err_o, 1'b0);

        // m1 locks; m0 waits with a stable request through 16 m1 grants.
        step(z, mk(0, 1, 32'h20, 0), g, dg0, dg1);
        chk("lock_first", dg1, 1'b1);
        for (int i = 1; i < MAX_LOCK; i++) begin
            step(mk(0, 0, 32'h1000, 0), mk(0, 1, 32'h20 + i, 0), g, dg0, dg1);
            chk("lock_hold", {dg0, dg1}, 2'b01);
        end
        step(mk(0, 0, 32'h1000, 0), mk(0, 1, 32'h40, 0), g, dg0, dg1);
        chk("lock_handover", {dg0, dg1}, 2'b10);
        step(z, z, g, dg0, dg1);

        // Reset lands right after an m1 read grant; its rvalid must never appear.
        step(z, mk(0, 0, 32'h40, 0), g, dg0, dg1);
        chk("pre_rst_gnt", dg1, 1'b1);
        rst = 1;
        rq.delete();
        last_rd[0] = 0; last_rd[1] = 0;
        own = -1; run = 0; pref = 0;
        m1_req_i = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 0;

        for (int i = 0; i < 8; i++) begin
            step(mk(0, 0, 32'h100 + i * 4, 0), mk(0, 0, 32'h2000 + i, 0), g, dg0, dg1);
            chk("alternate", {dg0, dg1}, (i % 2) ? 2'b01 : 2'b10);
        end

        pa = z; pb = z;
        for (int i = 0; i < 2000; i++) begin
            step(pa, pb, g, dg0, dg1);
            if (!pa.req || g == 0) pa = rnd();
            if (!pb.req || g == 1) pb = rnd();
        end
        repeat (3) step(z, z, g, dg0, dg1);
        chk("drain", rq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
